// File: rtl/apb_rst_seq.sv
// APB-programmable reset sequencer: holds all domains in reset, then releases them in index order.
// Optional CAUSE register (sticky por/pmu/soft flags at offset 0x0C) enabled by APB_RST_SEQ_CAUSE_EN.
module apb_rst_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RST    = 4
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  rst_req_n,
  output logic [NUM_RST-1:0]    rst_n_o,
  output logic                  done
);

  localparam int IDX_W = $clog2(NUM_RST);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_RST-1:0]    rst_n_q, rst_n_d;
  logic [15:0]           hold_q, hold_d;
  logic [15:0]           step_q, step_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic        wr_stb, rd_stb, soft_trig, trigger;
  logic [7:0]  offset;
  logic [15:0] hold_eff, step_eff;
  logic [31:0] status, rd_val;
  logic        unused_bits;

  assign wr_stb    = psel & penable & pwrite;
  assign rd_stb    = psel & ~penable & ~pwrite;
  assign offset    = paddr[7:0];
  assign soft_trig = wr_stb && (offset == 8'h00) && pwdata[0];
  assign trigger   = ~rst_req_n | soft_trig;
  assign unused_bits = ^{paddr, pwdata};

  // A programmed delay of zero behaves as a single-cycle delay.
  assign hold_eff = (hold_q == 16'd0) ? 16'd1 : hold_q;
  assign step_eff = (step_q == 16'd0) ? 16'd1 : step_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    if (trigger) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_n_d = '0;
          if (cnt_q == hold_eff - 16'd1) begin
            state_d    = ST_RELEASE;
            rst_n_d[0] = 1'b1;
            idx_d      = IDX_W'(1);
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == step_eff - 16'd1) begin
            rst_n_d[idx_q] = 1'b1;
            idx_d          = idx_q + IDX_W'(1);
            cnt_d          = '0;
            if (idx_q == IDX_W'(NUM_RST - 1)) state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_DONE: begin
          rst_n_d = '1;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    status                = '0;
    status[0]             = (state_q != ST_DONE);
    status[2:1]           = state_q;
    status[NUM_RST+3:4]   = rst_n_q;
  end

`ifdef APB_RST_SEQ_CAUSE_EN
  logic [2:0] cause_q, cause_d, cause_set, cause_clr;
  assign cause_set = {soft_trig, ~rst_req_n, 1'b0};
  assign cause_clr = (wr_stb && (offset == 8'h0C)) ? pwdata[2:0] : 3'b000;
  assign cause_d   = (cause_q & ~cause_clr) | cause_set;

  always_ff @(posedge pclk) begin
    if (preset) cause_q <= 3'b001;
    else        cause_q <= cause_d;
  end
`endif

  always_comb begin
    rd_val = '0;
    case (offset)
      8'h04:   rd_val = {step_q, hold_q};
      8'h08:   rd_val = status;
`ifdef APB_RST_SEQ_CAUSE_EN
      8'h0C:   rd_val = {29'd0, cause_q};
`endif
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    hold_d   = hold_q;
    step_d   = step_q;
    prdata_d = prdata_q;
    if (wr_stb && (offset == 8'h04)) begin
      hold_d = pwdata[15:0];
      step_d = pwdata[31:16];
    end
    if (rd_stb) prdata_d = DATA_WIDTH'(rd_val);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= ST_ASSERT;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_n_q  <= '0;
      hold_q   <= 16'd16;
      step_q   <= 16'd8;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_n_q  <= rst_n_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      prdata_q <= prdata_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign done    = (state_q == ST_DONE);
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_rst_seq.sv
// Bench for apb_rst_seq: directed release-timing checks plus random APB/PMU traffic against a timeline model.
module tb_apb_rst_seq;
  localparam int NR = 4;

  logic          pclk = 1'b0;
  logic          preset, psel, penable, pwrite, rst_req_n;
  logic [31:0]   paddr, pwdata;
  logic [31:0]   prdata;
  logic [NR-1:0] rst_n_o;
  logic          done;

  apb_rst_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_RST(NR)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .rst_req_n(rst_req_n),
    .rst_n_o(rst_n_o), .done(done)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Timeline model: bit i is released he + i*se cycles after the last trigger edge.
  int            cyc = 0;
  int            t_last = 0;
  bit            seq_done = 1'b0;
  logic [15:0]   hold_m = 16'd16, step_m = 16'd8;
  logic [2:0]    cause_m = 3'b000;
  logic [31:0]   exp_prdata = '0;
  logic [NR-1:0] exp_rst = '0;
  logic          exp_done = 1'b0;

  function automatic logic [NR-1:0] rel_bits(input int el, input logic [15:0] h, input logic [15:0] s);
    int he, se;
    logic [NR-1:0] r;
    he = (h == 16'd0) ? 1 : int'(h);
    se = (s == 16'd0) ? 1 : int'(s);
    for (int i = 0; i < NR; i++) r[i] = (el >= he + i * se);
    return r;
  endfunction

  function automatic logic [31:0] read_model(input logic [7:0] off, input logic [NR-1:0] r);
    logic [31:0] v;
    v = 32'd0;
    case (off)
      8'h04: v = {step_m, hold_m};
      8'h08: begin
        v[0]      = ~(&r);
        v[2:1]    = (&r) ? 2'd2 : ((r == '0) ? 2'd0 : 2'd1);
        v[NR+3:4] = r;
      end
`ifdef APB_RST_SEQ_CAUSE_EN
      8'h0C: v = {29'd0, cause_m};
`endif
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  always @(posedge pclk) begin
    logic [2:0] set_v, clr_v;
    cyc = cyc + 1;
    if (preset) begin
      t_last = cyc; seq_done = 1'b0; hold_m = 16'd16; step_m = 16'd8;
      exp_prdata = '0; cause_m = 3'b001;
    end else begin
      if (psel && !penable && !pwrite) exp_prdata = read_model(paddr[7:0], exp_rst);
      set_v = {psel && penable && pwrite && paddr[7:0] == 8'h00 && pwdata[0], !rst_req_n, 1'b0};
      clr_v = (psel && penable && pwrite && paddr[7:0] == 8'h0C) ? pwdata[2:0] : 3'b000;
      cause_m = (cause_m & ~clr_v) | set_v;
      if (psel && penable && pwrite && paddr[7:0] == 8'h04) begin
        hold_m = pwdata[15:0];
        step_m = pwdata[31:16];
      end
      if (set_v != 3'b000) begin
        t_last = cyc; seq_done = 1'b0;
      end
    end
    if (seq_done) exp_rst = '1;
    else exp_rst = rel_bits(cyc - t_last, hold_m, step_m);
    if (&exp_rst) seq_done = 1'b1;
    exp_done = &exp_rst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    check("rst_n_o", 32'(rst_n_o), 32'(exp_rst));
    check("done", 32'(done), 32'(exp_done));
    check("prdata", prdata, exp_prdata);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] cause_exp;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rst_req_n = 1'b1;
    idle(3);
    check("reset_rst", 32'(rst_n_o), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_prdata", prdata, 32'h0);

    // Power-on sequence with default 16/8 timing.
    preset = 1'b0;
    idle(15);
    check("por_c15", 32'(rst_n_o), 32'h0);
    tick();
    check("por_c16", 32'(rst_n_o), 32'h1);
    idle(8);
    check("por_c24", 32'(rst_n_o), 32'h3);
    idle(8);
    check("por_c32", 32'(rst_n_o), 32'h7);
    idle(7);
    check("por_c39", 32'(done), 32'h0);
    tick();
    check("por_c40", 32'(rst_n_o), 32'hF);
    check("por_done", 32'(done), 32'h1);

    apb_read(32'h08);
    check("status_done", prdata, 32'hF4);
    apb_read(32'h04);
    check("delay_default", prdata, 32'h0008_0010);

    // Soft reset from DONE, then STATUS mid-release.
    apb_write(32'h00, 32'h1);
    check("soft_rst", 32'(rst_n_o), 32'h0);
    check("soft_done", 32'(done), 32'h0);
    idle(15);
    check("soft_c15", 32'(rst_n_o), 32'h0);
    tick();
    check("soft_c16", 32'(rst_n_o), 32'h1);
    idle(8);
    check("soft_c24", 32'(rst_n_o), 32'h3);
    apb_read(32'h08);
    check("status_rel", prdata, 32'h33);

    // PMU request for 50 cycles while releasing.
    rst_req_n = 1'b0;
    tick();
    check("pmu_assert", 32'(rst_n_o), 32'h0);
    idle(49);
    check("pmu_held", 32'(rst_n_o), 32'h0);
    rst_req_n = 1'b1;
    idle(15);
    check("pmu_c15", 32'(rst_n_o), 32'h0);
    tick();
    check("pmu_c16", 32'(rst_n_o), 32'h1);
    idle(30);

    // Zero delays: one bit per cycle.
    apb_write(32'h04, 32'h0);
    apb_write(32'h00, 32'h1);
    check("zero_entry", 32'(rst_n_o), 32'h0);
    tick(); check("zero_b0", 32'(rst_n_o), 32'h1);
    tick(); check("zero_b1", 32'(rst_n_o), 32'h3);
    tick(); check("zero_b2", 32'(rst_n_o), 32'h7);
    tick(); check("zero_b3", 32'(rst_n_o), 32'hF);
    check("zero_done", 32'(done), 32'h1);

    // PMU request coincident with a soft reset write.
    rst_req_n = 1'b0;
    apb_write(32'h00, 32'h1);
    rst_req_n = 1'b1;
    idle(6);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 6))
        0: if (exp_done) apb_write(32'h04, {16'($urandom_range(0, 6)), 16'($urandom_range(0, 12))});
           else tick();
        1: apb_write({24'($urandom), 8'h00}, 32'($urandom_range(0, 1)));
        2: begin
          case ($urandom_range(0, 4))
            0: apb_read({24'($urandom), 8'h00});
            1: apb_read({24'($urandom), 8'h04});
            2: apb_read({24'($urandom), 8'h08});
            3: apb_read({24'($urandom), 8'h0C});
            default: apb_read({24'($urandom), 8'($urandom)});
          endcase
        end
        3: begin
          rst_req_n = 1'b0;
          idle($urandom_range(1, 5));
          rst_req_n = 1'b1;
        end
        4: idle($urandom_range(1, 30));
        5: apb_write(32'h0C, 32'($urandom_range(0, 7)));
        default: apb_write(32'h08, $urandom);
      endcase
    end
    idle(100);

    apb_read(32'h10);
    check("unmapped", prdata, 32'h0);

    // Cause register after preset plus soft reset.
    preset = 1'b1;
    idle(2);
    preset = 1'b0;
    apb_write(32'h00, 32'h1);
    apb_read(32'h0C);
`ifdef APB_RST_SEQ_CAUSE_EN
    cause_exp = 32'h5;
`else
    cause_exp = 32'h0;
`endif
    check("cause_rd", prdata, cause_exp);
    apb_write(32'h0C, 32'h5);
    apb_read(32'h0C);
    check("cause_clr", prdata, 32'h0);
    idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
